// File: rtl/reset_sequencer.sv
// reset_sequencer: lock-qualified, staggered reset generator.
// Holds NCH reset domains asserted until the reset release and the clock-source
// lock have both been synchronised, waits HOLD cycles, then releases the domains
// one by one in index order, STAGGER cycles apart. A lock loss or a soft-reset
// request re-asserts every domain and re-runs the sequence.
module reset_sequencer #(
  parameter int NCH     = 2,
  parameter int HOLD    = 64,
  parameter int STAGGER = 16,
  parameter int SYNC    = 2
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_pll_lock,
  input  logic           i_soft_rst,
  output logic [NCH-1:0] o_rst,
  output logic           o_ready
);

  localparam int CNT_MAX = (HOLD > STAGGER) ? HOLD : STAGGER;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = $clog2(NCH + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD - 1);
  localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NCH - 1);

  typedef enum logic [1:0] {
    S_WAIT_LOCK = 2'd0,
    S_HOLD      = 2'd1,
    S_STAGGER   = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  // Synchroniser chains
  logic [SYNC-1:0] r_rst_sync;
  logic [SYNC-1:0] r_lock_sync;
  logic            w_rst_ok;
  logic            w_lock_s;

  // FSM registers and their next values
  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_next;
  logic [NCH-1:0]   r_rst;
  logic [NCH-1:0]   w_rst_next;
  logic             r_ready;
  logic             w_ready_next;

  // One-hot select of the channel that r_idx points at
  logic [NCH-1:0]   w_sel;

  assign w_rst_ok = r_rst_sync[SYNC-1];
  assign w_lock_s = r_lock_sync[SYNC-1];

  for (genvar gi = 0; gi < NCH; gi++) begin : g_sel
    assign w_sel[gi] = (r_idx == IDX_W'(gi));
  end

  // Reset-release synchroniser: shifts ones in after i_rst_n deasserts
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rst_sync <= '0;
    end else begin
      r_rst_sync <= {r_rst_sync[SYNC-2:0], 1'b1};
    end
  end

  // Lock synchroniser: only its last stage is used by the FSM
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lock_sync <= '0;
    end else begin
      r_lock_sync <= {r_lock_sync[SYNC-2:0], i_pll_lock};
    end
  end

  // FSM state, counters and registered reset outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_WAIT_LOCK;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_rst   <= '1;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_idx   <= w_idx_next;
      r_rst   <= w_rst_next;
      r_ready <= w_ready_next;
    end
  end

  // Next-state logic: lock loss beats soft reset beats normal sequencing
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_idx_next   = r_idx;
    w_rst_next   = r_rst;
    w_ready_next = r_ready;

    if (r_state == S_WAIT_LOCK) begin
      w_rst_next   = '1;
      w_ready_next = 1'b0;
      if (w_rst_ok && w_lock_s) begin
        w_state_next = S_HOLD;
        w_cnt_next   = '0;
        w_idx_next   = '0;
      end
    end else if (!w_lock_s) begin
      w_state_next = S_WAIT_LOCK;
      w_rst_next   = '1;
      w_ready_next = 1'b0;
      w_cnt_next   = '0;
      w_idx_next   = '0;
    end else if (i_soft_rst) begin
      // Partial counts are discarded and released channels are reasserted
      w_state_next = S_HOLD;
      w_rst_next   = '1;
      w_ready_next = 1'b0;
      w_cnt_next   = '0;
      w_idx_next   = '0;
    end else begin
      case (r_state)
        S_HOLD: begin
          if (r_cnt == HOLD_LAST) begin
            w_rst_next[0] = 1'b0;
            w_cnt_next    = '0;
            w_idx_next    = IDX_W'(1);
            if (NCH == 1) begin
              w_state_next = S_RUN;
              w_ready_next = 1'b1;
            end else begin
              w_state_next = S_STAGGER;
            end
          end else begin
            w_cnt_next = r_cnt + CNT_W'(1);
          end
        end
        S_STAGGER: begin
          if (r_cnt == STAG_LAST) begin
            w_rst_next = r_rst & ~w_sel;
            w_cnt_next = '0;
            w_idx_next = r_idx + IDX_W'(1);
            if (r_idx == IDX_LAST) begin
              w_state_next = S_RUN;
              w_ready_next = 1'b1;
            end
          end else begin
            w_cnt_next = r_cnt + CNT_W'(1);
          end
        end
        S_RUN: begin
          w_rst_next   = '0;
          w_ready_next = 1'b1;
        end
        default: begin
          w_state_next = S_WAIT_LOCK;
          w_rst_next   = '1;
          w_ready_next = 1'b0;
        end
      endcase
    end
  end

  assign o_rst   = r_rst;
  assign o_ready = r_ready;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed testbench for reset_sequencer: a NCH=3/HOLD=64/STAGGER=16 instance
// for the main sequences and a NCH=1/HOLD=1/STAGGER=1 instance for the corner.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pll_lock;
  logic       soft_rst;
  logic [2:0] o_rst;
  logic       o_ready;

  logic       c_rst_n;
  logic       c_lock;
  logic       c_soft;
  logic [0:0] c_rst;
  logic       c_ready;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  reset_sequencer #(.NCH(3), .HOLD(64), .STAGGER(16), .SYNC(2)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_pll_lock (pll_lock),
    .i_soft_rst (soft_rst),
    .o_rst      (o_rst),
    .o_ready    (o_ready)
  );

  reset_sequencer #(.NCH(1), .HOLD(1), .STAGGER(1), .SYNC(2)) dut_c (
    .i_clk      (clk),
    .i_rst_n    (c_rst_n),
    .i_pll_lock (c_lock),
    .i_soft_rst (c_soft),
    .o_rst      (c_rst),
    .o_ready    (c_ready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s got=%0h t=%0t", tag, got, $time);
    end
  endtask

  // Advance n rising edges, ending 1 time unit after the last one
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called just after an edge; HOLD is entered 'lead' edges from now (t0).
  // Expected: bit0 falls at t0+64, bit1 at t0+80, bit2 and o_ready at t0+96.
  task automatic seq_check(input string tag, input int lead);
    step(lead + 63);
    chk({tag, "_t63"}, 32'(o_rst), 32'h7);
    step(1);
    chk({tag, "_t64"}, 32'(o_rst), 32'h6);
    step(15);
    chk({tag, "_t79"}, 32'(o_rst), 32'h6);
    step(1);
    chk({tag, "_t80"}, 32'(o_rst), 32'h4);
    chk({tag, "_t80rdy"}, 32'(o_ready), 32'h0);
    step(15);
    chk({tag, "_t95"}, 32'(o_rst), 32'h4);
    step(1);
    chk({tag, "_t96"}, 32'(o_rst), 32'h0);
    chk({tag, "_t96rdy"}, 32'(o_ready), 32'h1);
  endtask

  initial begin
    logic bad;
    rst_n    = 1'b1;
    pll_lock = 1'b1;
    soft_rst = 1'b0;
    c_rst_n  = 1'b1;
    c_lock   = 1'b1;
    c_soft   = 1'b0;
    #2;
    rst_n   = 1'b0;
    c_rst_n = 1'b0;
    step(3);

    // Reset state
    chk("rst_orst", 32'(o_rst), 32'h7);
    chk("rst_ready", 32'(o_ready), 32'h0);
    chk("c_rst_orst", 32'(c_rst), 32'h1);
    chk("c_rst_ready", 32'(c_ready), 32'h0);

    // Test 1: power-up with lock already high
    rst_n = 1'b1;
    seq_check("pwr", 3);

    // Test 2: lock arrives 500 cycles after reset release
    rst_n    = 1'b0;
    pll_lock = 1'b0;
    step(2);
    rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 500; i++) begin
      step(1);
      if (o_rst !== 3'b111 || o_ready !== 1'b0) bad = 1'b1;
    end
    chk("late_held", 32'(bad), 32'h0);
    pll_lock = 1'b1;
    seq_check("late", 3);

    // Test 3: single-cycle soft reset in RUN
    step(5);
    soft_rst = 1'b1;
    step(1);
    soft_rst = 1'b0;
    chk("soft_orst", 32'(o_rst), 32'h7);
    chk("soft_ready", 32'(o_ready), 32'h0);
    seq_check("soft", 0);

    // Test 3b: soft reset held high keeps restarting HOLD
    soft_rst = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (o_rst !== 3'b111 || o_ready !== 1'b0) bad = 1'b1;
    end
    soft_rst = 1'b0;
    chk("softhold_held", 32'(bad), 32'h0);
    seq_check("softhold", 0);

    // Test 4: lock drop between bit0 and bit1 release
    soft_rst = 1'b1;
    step(1);
    soft_rst = 1'b0;
    step(64);
    chk("drop_bit0", 32'(o_rst), 32'h6);
    step(5);
    pll_lock = 1'b0;
    step(2);
    chk("drop_e2", 32'(o_rst), 32'h6);
    step(1);
    chk("drop_e3", 32'(o_rst), 32'h7);
    chk("drop_e3rdy", 32'(o_ready), 32'h0);
    bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (o_rst !== 3'b111 || o_ready !== 1'b0) bad = 1'b1;
    end
    chk("drop_held", 32'(bad), 32'h0);
    pll_lock = 1'b1;
    seq_check("relock", 3);

    // Test 5: async reset between edges while in HOLD
    soft_rst = 1'b1;
    step(1);
    soft_rst = 1'b0;
    step(10);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_hold_orst", 32'(o_rst), 32'h7);
    chk("async_hold_rdy", 32'(o_ready), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seq_check("async_hold", 3);

    // Test 5b: async reset between edges while in RUN
    step(3);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_run_orst", 32'(o_rst), 32'h7);
    chk("async_run_rdy", 32'(o_ready), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seq_check("async_run", 3);

    // Test 6: NCH=1, HOLD=1, STAGGER=1 corner
    c_rst_n = 1'b1;
    step(3);
    chk("c_t0_orst", 32'(c_rst), 32'h1);
    chk("c_t0_rdy", 32'(c_ready), 32'h0);
    step(1);
    chk("c_t1_orst", 32'(c_rst), 32'h0);
    chk("c_t1_rdy", 32'(c_ready), 32'h1);
    c_soft = 1'b1;
    step(1);
    c_soft = 1'b0;
    chk("c_soft_orst", 32'(c_rst), 32'h1);
    chk("c_soft_rdy", 32'(c_ready), 32'h0);
    step(1);
    chk("c_soft1_orst", 32'(c_rst), 32'h0);
    chk("c_soft1_rdy", 32'(c_ready), 32'h1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
